// File: rtl/icache_direct_pkg.sv
// Shared cache types: word type, fetch-address overlay, frame layout and icache FSM states.
// The struct widths here match the default 16-frame geometry.
package icache_direct_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_NFRAMES = 16;
    localparam int ICACHE_IDXW    = $clog2(ICACHE_NFRAMES);
    localparam int ICACHE_TAGW    = 30 - ICACHE_IDXW;

    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDXW-1:0] idx;
        logic [1:0]             bytoff;
    } icachef_t;

    typedef struct packed {
        logic                   valid;
        logic [ICACHE_TAGW-1:0] tag;
        word_t                  data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        FETCH
    } icache_state_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache: combinational hit path, one-word fill on miss.
// The frame array and the IDLE/FETCH controller live together in this module.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int NFRAMES = ICACHE_NFRAMES
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output word_t imemload,
    output logic  ihit,
    output logic  iREN,
    output word_t iaddr,
    input  word_t iload,
    input  logic  iwait
);

    localparam int IDXW = $clog2(NFRAMES);
    localparam int TAGW = 30 - IDXW;

    // Local copies of the package overlays, sized for this instance's NFRAMES.
    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [IDXW-1:0] idx;
        logic [1:0]      bytoff;
    } addr_t;

    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] tag;
        word_t           data;
    } frame_t;

    frame_t        frames [NFRAMES];
    icache_state_t state, next_state;
    addr_t         req, miss;
    frame_t        cur;
    logic          hit, fill;

    assign req = addr_t'(imemaddr);
    assign cur = frames[req.idx];
    assign hit = imemREN && cur.valid && (cur.tag == req.tag);

    logic unused_bytoff;
    assign unused_bytoff = &{1'b0, req.bytoff};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            miss  <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && imemREN && !hit)
                miss <= addr_t'({imemaddr[31:2], 2'b00});
        end
    end

    // Fill always targets the latched miss address, never the live fetch address.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NFRAMES; i++)
                frames[i].valid <= 1'b0;
        end else if (fill) begin
            frames[miss.idx] <= '{valid: 1'b1, tag: miss.tag, data: iload};
        end
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        fill       = 1'b0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    ihit     = 1'b1;
                    imemload = cur.data;
                end else if (imemREN) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = word_t'(miss);
                if (!iwait) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios plus random fetch traffic against a
// behavioural cache model (index/tag by arithmetic, arrays of valid/tag/data).
module tb_icache_direct;
    import icache_direct_pkg::*;

    logic  CLK = 1'b0;
    logic  RST;
    logic  imemREN;
    word_t imemaddr;
    word_t imemload;
    logic  ihit;
    logic  iREN;
    word_t iaddr;
    word_t iload;
    logic  iwait;

    int tests = 0;
    int fails = 0;

    bit    ref_valid [16];
    word_t ref_tag   [16];
    word_t ref_data  [16];
    word_t memdat    [word_t];

    icache_direct dut (
        .CLK     (CLK),
        .RST     (RST),
        .imemREN (imemREN),
        .imemaddr(imemaddr),
        .imemload(imemload),
        .ihit    (ihit),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iload   (iload),
        .iwait   (iwait)
    );

    always #5 CLK = ~CLK;

    function automatic word_t mem_val(input word_t a);
        word_t w;
        w = a & 32'hFFFF_FFFC;
        if (memdat.exists(w)) return memdat[w];
        return (w * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic int ref_idx(input word_t a);
        return int'((a >> 2) % 32'd16);
    endfunction

    function automatic bit ref_hit(input word_t a);
        return ref_valid[ref_idx(a)] && (ref_tag[ref_idx(a)] == (a >> 6));
    endfunction

    // One fetch from the datapath side, playing memory with 'waits' busy cycles on a miss.
    task automatic do_fetch(input word_t a, input int waits, output word_t got);
        word_t wa;
        int    idx;
        wa  = {a[31:2], 2'b00};
        idx = ref_idx(a);
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1; iload = $urandom; #1;
        if (ref_hit(a)) begin
            tests++;
            if ({ihit, iREN, iaddr, imemload} !== {1'b1, 1'b0, 32'h0, ref_data[idx]})
                begin fails++; $display("FAIL hit addr=%h got ihit=%b iREN=%b iaddr=%h load=%h want load=%h",
                                  a, ihit, iREN, iaddr, imemload, ref_data[idx]); end
            got = imemload;
            return;
        end
        tests++;
        if ({ihit, iREN, iaddr, imemload} !== 66'h0)
            begin fails++; $display("FAIL miss_idle addr=%h got ihit=%b iREN=%b iaddr=%h load=%h want all 0",
                              a, ihit, iREN, iaddr, imemload); end
        for (int i = 0; i <= waits; i++) begin
            @(negedge CLK);
            iwait = (i < waits);
            iload = (i < waits) ? $urandom : mem_val(a);
            #1;
            tests++;
            if ({ihit, iREN, iaddr, imemload} !== {1'b0, 1'b1, wa, 32'h0})
                begin fails++; $display("FAIL fetch addr=%h cyc=%0d got ihit=%b iREN=%b iaddr=%h load=%h want iREN=1 iaddr=%h",
                                  a, i, ihit, iREN, iaddr, imemload, wa); end
        end
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = a >> 6;
        ref_data[idx]  = mem_val(a);
        @(negedge CLK);
        iwait = 1'b1; iload = $urandom; #1;
        tests++;
        if ({ihit, iREN, iaddr, imemload} !== {1'b1, 1'b0, 32'h0, ref_data[idx]})
            begin fails++; $display("FAIL fill_hit addr=%h got ihit=%b iREN=%b iaddr=%h load=%h want load=%h",
                              a, ihit, iREN, iaddr, imemload, ref_data[idx]); end
        got = imemload;
    endtask

    task automatic test_reset();
        RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
        repeat (2) @(negedge CLK);
        #1;
        tests++;
        if ({ihit, iREN, iaddr, imemload} !== 66'h0)
            begin fails++; $display("FAIL reset got ihit=%b iREN=%b iaddr=%h load=%h want all 0",
                              ihit, iREN, iaddr, imemload); end
        @(negedge CLK);
        RST = 1'b0; imemREN = 1'b0;
    endtask

    task automatic test_cold_miss();
        word_t got;
        memdat[32'h0] = 32'h3C01_0001;
        do_fetch(32'h0, 2, got);
        tests++;
        if (got !== 32'h3C01_0001)
            begin fails++; $display("FAIL cold_miss got %h want 3c010001", got); end
    endtask

    task automatic test_hit_offset();
        word_t got;
        do_fetch(32'h0, 0, got);
        do_fetch(32'h2, 0, got);
        tests++;
        if (got !== 32'h3C01_0001)
            begin fails++; $display("FAIL hit_offset got %h want 3c010001", got); end
    endtask

    task automatic test_conflict();
        word_t got;
        memdat[32'h4]  = 32'hAAAA_AAAA;
        memdat[32'h44] = 32'hBBBB_BBBB;
        do_fetch(32'h4, 1, got);
        do_fetch(32'h44, 1, got);
        tests++;
        if (got !== 32'hBBBB_BBBB)
            begin fails++; $display("FAIL conflict_new got %h want bbbbbbbb", got); end
        do_fetch(32'h4, 1, got);
        tests++;
        if (got !== 32'hAAAA_AAAA)
            begin fails++; $display("FAIL conflict_old got %h want aaaaaaaa", got); end
    endtask

    task automatic test_addr_change();
        word_t got;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1; #1;
        @(negedge CLK); #1;
        @(negedge CLK);
        imemaddr = 32'h20; #1;
        tests++;
        if ({iREN, iaddr} !== {1'b1, 32'h10})
            begin fails++; $display("FAIL addr_hold got iREN=%b iaddr=%h want 1 00000010", iREN, iaddr); end
        @(negedge CLK);
        iwait = 1'b0; iload = mem_val(32'h10); #1;
        tests++;
        if ({iREN, iaddr} !== {1'b1, 32'h10})
            begin fails++; $display("FAIL addr_fill got iREN=%b iaddr=%h want 1 00000010", iREN, iaddr); end
        ref_valid[4] = 1'b1; ref_tag[4] = 32'h0; ref_data[4] = mem_val(32'h10);
        @(negedge CLK);
        iwait = 1'b1; iload = $urandom; #1;
        tests++;
        if ({ihit, iREN} !== 2'b00)
            begin fails++; $display("FAIL addr_newmiss got ihit=%b iREN=%b want 0 0", ihit, iREN); end
        @(negedge CLK); #1;
        tests++;
        if ({iREN, iaddr} !== {1'b1, 32'h20})
            begin fails++; $display("FAIL addr_newreq got iREN=%b iaddr=%h want 1 00000020", iREN, iaddr); end
        @(negedge CLK);
        iwait = 1'b0; iload = mem_val(32'h20); #1;
        ref_valid[8] = 1'b1; ref_tag[8] = 32'h0; ref_data[8] = mem_val(32'h20);
        @(negedge CLK);
        iwait = 1'b1; #1;
        tests++;
        if ({ihit, imemload} !== {1'b1, mem_val(32'h20)})
            begin fails++; $display("FAIL addr_newhit got ihit=%b load=%h want 1 %h", ihit, imemload, mem_val(32'h20)); end
        do_fetch(32'h10, 0, got);
    endtask

    task automatic test_reset_mid_fetch();
        word_t got;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h8; iwait = 1'b1; #1;
        @(negedge CLK); #1;
        tests++;
        if (iREN !== 1'b1)
            begin fails++; $display("FAIL rst_pre got iREN=%b want 1", iREN); end
        #2 RST = 1'b1;
        #1;
        tests++;
        if ({iREN, iaddr} !== 33'h0)
            begin fails++; $display("FAIL rst_async got iREN=%b iaddr=%h want 0 0", iREN, iaddr); end
        @(negedge CLK);
        RST = 1'b0; imemREN = 1'b0;
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        do_fetch(32'h0, 1, got);
        do_fetch(32'h8, 0, got);
    endtask

    task automatic test_ren_low();
        word_t got;
        do_fetch(32'h0, 0, got);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            imemREN = 1'b0; imemaddr = 32'h0; #1;
            tests++;
            if ({ihit, iREN, iaddr, imemload} !== 66'h0)
                begin fails++; $display("FAIL ren_low cyc=%0d got ihit=%b iREN=%b iaddr=%h load=%h want all 0",
                                  i, ihit, iREN, iaddr, imemload); end
        end
        @(negedge CLK);
        imemREN = 1'b1; #1;
        tests++;
        if ({ihit, iREN, imemload} !== {1'b1, 1'b0, ref_data[0]})
            begin fails++; $display("FAIL ren_resume got ihit=%b iREN=%b load=%h want 1 0 %h",
                              ihit, iREN, imemload, ref_data[0]); end
    endtask

    task automatic test_random();
        word_t got, a;
        for (int n = 0; n < 200; n++) begin
            a = (word_t'($urandom_range(0, 3)) << 8) | (word_t'($urandom_range(0, 15)) << 2)
              | word_t'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                @(negedge CLK);
                imemREN = 1'b0; imemaddr = a; #1;
                tests++;
                if ({ihit, iREN, iaddr, imemload} !== 66'h0)
                    begin fails++; $display("FAIL rand_idle addr=%h got ihit=%b iREN=%b iaddr=%h load=%h want all 0",
                                      a, ihit, iREN, iaddr, imemload); end
            end else begin
                do_fetch(a, $urandom_range(0, 3), got);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        test_reset();
        test_cold_miss();
        test_hit_offset();
        test_conflict();
        test_addr_change();
        test_reset_mid_fetch();
        test_ren_low();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port (imemREN/imemaddr/imemload/ihit) and the memory controller's instruction port.
- Hits return the word combinationally in the same cycle.
- Misses stall fetch while one word is fetched from memory and installed.
- Direct downstream neighbour of the datapath; feeds its IF stage.

Parameters:
- NFRAMES, 16: number of one-word frames; power of 2, at least 2.
- IDXW, $clog2(NFRAMES): index width (4 at default).
- TAGW, 30-IDXW: tag width (26 at default).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- imemload  out  32  fetched instruction; valid only when ihit=1.
- ihit  out  1  fetch satisfied this cycle.
- iREN  out  1  read request to the memory controller.
- iaddr  out  32  word-aligned address to the memory controller.
- iload  in  32  memory return data.
- iwait  in  1  memory busy. iwait=0 while iREN=1 means iload is valid this cycle.

Behaviour:
- Address split: tag=imemaddr[31:IDXW+2], idx=imemaddr[IDXW+1:2], byte offset=[1:0] ignored.
- Storage per frame: valid bit, TAGW tag, 32-bit data, held in flops.
- Reset (asynchronous, RST=1):
  - All valid bits cleared; tags and data don't-care.
  - State=IDLE.
  - Outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
- FSM states are IDLE and FETCH.
- IDLE:
  - hit = imemREN & valid[idx] & (tag[idx]==tag). On hit: ihit=1, imemload=data[idx] in the same cycle, 0-cycle latency.
  - On imemREN & !hit: latch miss_addr={imemaddr[31:2],2'b00}, go to FETCH. ihit=0 this cycle.
  - imemREN=0: ihit=0, imemload=0, stay in IDLE.
- FETCH:
  - Drive iREN=1 and iaddr=miss_addr. Outputs ihit=0, imemload=0.
  - While iwait=1: stay in FETCH; iaddr holds stable.
  - When iwait=0: on that edge write frame[miss idx] with valid=1, tag=miss tag, data=iload; return to IDLE.
  - The following cycle re-looks-up the current imemaddr and hits if unchanged. Total miss latency = memory wait cycles + 2 cycles.
- Transaction rules:
  - The fill uses miss_addr, not the live imemaddr. A changed imemaddr or a dropped imemREN during FETCH does not abort the fill; the frame is still installed.
  - No fill-forwarding: data is never returned in the same cycle iwait falls.
  - A conflicting miss (same idx, different tag) overwrites the frame; no victim handling, the cache is read-only.
- In IDLE, iREN=0 and iaddr=0.
- RST asserted mid-FETCH: iREN drops immediately (asynchronously); no frame is written; valid bits are cleared.
- There is no flush or invalidate input. Self-modifying code is unsupported.
- Simultaneous hit and fill cannot occur: hits are only evaluated in IDLE.

Decomposition:
- Add to the existing cache types package: typedef icachef_t packed {tag[TAGW], idx[IDXW], bytoff[2]} overlaid on word_t.
- Add typedef icache_frame_t packed {valid, tag, data}.
- Add enum icache_state_t {IDLE, FETCH}.
- Reuse word_t from cpu_types_pkg.
- No sub-module: the frame array and FSM stay in one module, about 130 lines.
- Datapath-side and memory-side ports map onto the existing datapath_cache_if (icache modport) and the cache-to-memory interface at integration. The standalone block exposes flat ports for bench use.

Test Plan:
1. Reset then cold miss: imemREN=1, imemaddr=0x00000000; memory returns 0x3C010001 after iwait held 2 cycles.
   -> iREN=1 with iaddr=0x00000000 for 3 cycles; ihit=0 throughout; next cycle ihit=1, imemload=0x3C010001.
2. Hit after fill: repeat the 0x00000000 fetch, then fetch 0x00000002.
   -> ihit=1 same cycle, iREN=0; the byte offset is ignored and 0x3C010001 is returned.
3. Conflict eviction: fill 0x00000004 (data 0xAAAAAAAA), then fetch 0x00000044 (same idx 1, data 0xBBBBBBBB), then fetch 0x00000004 again.
   -> 0x00000044 misses then hits with 0xBBBBBBBB; 0x00000004 misses again and iREN reasserts with iaddr=0x00000004.
4. Address change mid-fetch: miss on 0x00000010; after 1 cycle in FETCH change imemaddr to 0x00000020.
   -> iaddr stays 0x00000010 until iwait=0; frame 4 valid afterward; a new miss is issued for 0x00000020.
5. Reset mid-FETCH: assert RST while iREN=1 and iwait=1.
   -> iREN=0 asynchronously; after release, the previously filled 0x00000000 misses (valid bits cleared).
6. imemREN=0 with a valid matching frame.
   -> ihit=0, imemload=0, iREN=0, state remains IDLE.
